descrypt_core_dispatch: RTL and testbench

- Single-clock scheduler between the word_gen extra-register stage and a bank of N_CORES descrypt core units.
- Hands each candidate word, with its tag (pkt_id, word_id, gen_id), to a free core in round-robin order.
- Tracks per-core busy state and counts words issued per generator run.
- Before a new comparator configuration is applied, it quiesces all cores and reports configuration application back to cmp_config.

---
 rtl/descrypt_core_dispatch.sv | 109 ++++++++++
 tb/tb_descrypt_core_dispatch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/descrypt_core_dispatch.sv
// descrypt_core_dispatch: round-robin word dispatcher for a bank of descrypt cores.
// Optional idle-cycle counter enabled by DESCRYPT_DISPATCH_IDLE_CNT_EN.
module descrypt_core_dispatch #(
    parameter int N_CORES = 4,
    parameter int WORD_W  = 56,
    parameter int TAG_W   = 64
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [WORD_W-1:0]  word_in,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic               gen_end_in,
    input  logic               word_empty,
    output logic               word_rd_en,
    output logic [WORD_W-1:0]  core_word,
    output logic [TAG_W-1:0]   core_tag,
    output logic [N_CORES-1:0] core_wr_en,
    input  logic [N_CORES-1:0] core_done,
    input  logic               new_cmp_config,
    output logic               config_applied,
    output logic               gen_done,
    output logic [31:0]        num_processed,
`ifdef DESCRYPT_DISPATCH_IDLE_CNT_EN
    output logic [31:0]        idle_cycles,
`endif
    output logic [N_CORES-1:0] busy_mask
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [2:0] {RUN, DRAIN_CFG, APPLY, DRAIN_END, REPORT} state_t;

    state_t             state, state_nx;
    logic [PW-1:0]      ptr, sel, idx;
    logic               found, issue, cfg_armed;
    logic [31:0]        cnt;
    logic [N_CORES-1:0] onehot;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = PW'((int'(ptr) + k) % N_CORES);
            if (!found && !busy_mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign issue          = (state == RUN) && !word_empty && !new_cmp_config && found;
    assign word_rd_en     = issue;
    assign onehot         = N_CORES'(1) << sel;
    assign config_applied = (state == APPLY);
    assign gen_done       = (state == REPORT);
    assign num_processed  = gen_done ? cnt : 32'd0;

    // A config still held high after APPLY must be seen low before it can trigger another drain.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:       state_nx = (issue && gen_end_in) ? DRAIN_END :
                                  (new_cmp_config && cfg_armed) ? DRAIN_CFG : RUN;
            DRAIN_CFG: state_nx = (busy_mask == '0) ? APPLY : DRAIN_CFG;
            APPLY:     state_nx = RUN;
            DRAIN_END: state_nx = (busy_mask == '0) ? REPORT : DRAIN_END;
            REPORT:    state_nx = RUN;
            default:   state_nx = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ptr        <= '0;
            busy_mask  <= '0;
            cnt        <= '0;
            core_wr_en <= '0;
            core_word  <= '0;
            core_tag   <= '0;
            cfg_armed  <= 1'b1;
        end else begin
            state      <= state_nx;
            busy_mask  <= (busy_mask & ~core_done) | (issue ? onehot : '0);
            core_wr_en <= issue ? onehot : '0;
            cnt        <= (state == REPORT) ? 32'd0 : cnt + 32'(issue);
            cfg_armed  <= (state == APPLY) ? !new_cmp_config : (cfg_armed || !new_cmp_config);
            if (issue) begin
                ptr       <= PW'((int'(sel) + 1) % N_CORES);
                core_word <= word_in;
                core_tag  <= tag_in;
            end
        end
    end

`ifdef DESCRYPT_DISPATCH_IDLE_CNT_EN
    logic stall;
    assign stall = (state == RUN) && !word_empty && !found;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            idle_cycles <= '0;
        else if (state == REPORT)
            idle_cycles <= '0;
        else if (stall && idle_cycles != 32'hFFFF_FFFF)
            idle_cycles <= idle_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_descrypt_core_dispatch.sv
// tb_descrypt_core_dispatch: directed checks of dispatch order, stalls, drains and reset.
module tb_descrypt_core_dispatch;
    logic        CLK = 1'b0;
    logic        rst;
    logic [55:0] word_in;
    logic [63:0] tag_in;
    logic        gen_end_in, word_empty, word_rd_en;
    logic [55:0] core_word;
    logic [63:0] core_tag;
    logic [3:0]  core_wr_en, core_done, busy_mask;
    logic        new_cmp_config, config_applied, gen_done;
    logic [31:0] num_processed;
`ifdef DESCRYPT_DISPATCH_IDLE_CNT_EN
    logic [31:0] idle_cycles;
`endif

    descrypt_core_dispatch #(.N_CORES(4), .WORD_W(56), .TAG_W(64)) dut (
        .CLK(CLK), .rst(rst), .word_in(word_in), .tag_in(tag_in),
        .gen_end_in(gen_end_in), .word_empty(word_empty), .word_rd_en(word_rd_en),
        .core_word(core_word), .core_tag(core_tag), .core_wr_en(core_wr_en),
        .core_done(core_done), .new_cmp_config(new_cmp_config),
        .config_applied(config_applied), .gen_done(gen_done),
        .num_processed(num_processed),
`ifdef DESCRYPT_DISPATCH_IDLE_CNT_EN
        .idle_cycles(idle_cycles),
`endif
        .busy_mask(busy_mask)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [55:0] w;
        logic [63:0] t;
        logic        ge;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_prev;

    function automatic logic [55:0] wv(input int i);
        return 56'hA5_0000_0000_0000 + 56'(i);
    endfunction

    function automatic logic [63:0] tv(input int i);
        return {32'h0000_0007, 16'h0042, 16'(i * 3)};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive();
        word_empty = (q.size() == 0);
        word_in    = word_empty ? 56'd0 : q[0].w;
        tag_in     = word_empty ? 64'd0 : q[0].t;
        gen_end_in = word_empty ? 1'b0 : q[0].ge;
    endtask

    task automatic push(input int i, input logic ge);
        ent_t e;
        e.w = wv(i);
        e.t = tv(i);
        e.ge = ge;
        q.push_back(e);
        drive();
    endtask

    // Advance one cycle: the source pops if the DUT asserted word_rd_en, then done is driven.
    task automatic cyc(input logic [3:0] d);
        rd_prev = word_rd_en;
        @(negedge CLK);
        if (rd_prev && q.size() != 0) q.delete(0);
        core_done = d;
        drive();
        #1;
    endtask

    initial begin
        rst = 1'b1; core_done = '0; new_cmp_config = 1'b0;
        drive();
        #1;
        check("rst_wr_en", core_wr_en, 0);
        check("rst_cfg_applied", config_applied, 0);
        check("rst_gen_done", gen_done, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_num", num_processed, 0);
        check("rst_word", core_word, 0);
        check("rst_tag", core_tag, 0);
        check("rst_rd", word_rd_en, 0);
        @(negedge CLK);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) push(i, 1'b0);
        #1;
        check("rr_rd0", word_rd_en, 1);
        cyc(4'b0000);
        check("rr_wr0", core_wr_en, 4'b0001);
        check("rr_word0", core_word, wv(1));
        check("rr_tag0", core_tag, tv(1));
        check("rr_rd1", word_rd_en, 1);
        cyc(4'b0000);
        check("rr_wr1", core_wr_en, 4'b0010);
        check("rr_rd2", word_rd_en, 1);
        cyc(4'b0000);
        check("rr_wr2", core_wr_en, 4'b0100);
        check("rr_rd3", word_rd_en, 1);
        cyc(4'b0000);
        check("rr_wr3", core_wr_en, 4'b1000);
        check("rr_word3", core_word, wv(4));
        check("rr_busy", busy_mask, 4'b1111);
        check("rr_stall_rd", word_rd_en, 0);
        cyc(4'b0000);
        check("rr_stall_wr", core_wr_en, 0);
        check("rr_stall_rd2", word_rd_en, 0);

        push(6, 1'b0);
        cyc(4'b0100);
        check("skip_done_cycle_rd", word_rd_en, 0);
        cyc(4'b0000);
        check("skip_busy", busy_mask, 4'b1011);
        check("skip_rd", word_rd_en, 1);
        cyc(4'b0000);
        check("skip_wr", core_wr_en, 4'b0100);
        check("skip_word", core_word, wv(5));
        check("skip_stall_rd", word_rd_en, 0);

        cyc(4'b0011);
        cyc(4'b0000);
        check("pre_rst_busy", busy_mask, 4'b1100);
        check("pre_rst_rd", word_rd_en, 1);
        cyc(4'b0000);
        check("pre_rst_wr", core_wr_en, 4'b0001);
        check("pre_rst_busy3", busy_mask, 4'b1101);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy_mask, 0);
        check("arst_wr", core_wr_en, 0);
        check("arst_word", core_word, 0);

        @(negedge CLK);
        rst = 1'b0;
        push(7, 1'b0);
        push(8, 1'b0);
        push(9, 1'b1);
        #1;
        check("gen_rd0", word_rd_en, 1);
        cyc(4'b0000);
        check("post_rst_wr_core0", core_wr_en, 4'b0001);
        check("gen_word0", core_word, wv(7));
        cyc(4'b0000);
        check("gen_wr1", core_wr_en, 4'b0010);
        check("gen_rd2", word_rd_en, 1);
        cyc(4'b0000);
        check("gen_wr2", core_wr_en, 4'b0100);
        check("gen_tag2", core_tag, tv(9));
        for (int n = 4; n <= 14; n++) begin
            cyc(n == 11 ? 4'b0001 : n == 12 ? 4'b0010 : n == 13 ? 4'b0100 : 4'b0000);
            check("gen_wait_done", gen_done, 0);
        end
        check("gen_busy_idle", busy_mask, 0);
        cyc(4'b0000);
        check("gen_done_pulse", gen_done, 1);
        check("gen_num", num_processed, 3);
        cyc(4'b0000);
        check("gen_done_end", gen_done, 0);
        check("gen_num_end", num_processed, 0);

        push(10, 1'b0);
        push(11, 1'b0);
        push(12, 1'b0);
        #1;
        check("cfg_rd0", word_rd_en, 1);
        cyc(4'b0000);
        check("cfg_wr0", core_wr_en, 4'b1000);
        check("cfg_rd1", word_rd_en, 1);
        cyc(4'b0000);
        check("cfg_wr1", core_wr_en, 4'b0001);
        new_cmp_config = 1'b1;
        #1;
        check("cfg_block_rd", word_rd_en, 0);
        cyc(4'b0000);
        check("cfg_drain_rd", word_rd_en, 0);
        check("cfg_drain_app", config_applied, 0);
        cyc(4'b1000);
        check("cfg_drain_rd2", word_rd_en, 0);
        cyc(4'b0001);
        check("cfg_busy1", busy_mask, 4'b0001);
        cyc(4'b0000);
        check("cfg_busy0", busy_mask, 0);
        check("cfg_app_early", config_applied, 0);
        cyc(4'b0000);
        check("cfg_applied", config_applied, 1);
        check("cfg_apply_rd", word_rd_en, 0);
        cyc(4'b0000);
        check("cfg_app_once", config_applied, 0);
        check("cfg_held_rd", word_rd_en, 0);
        cyc(4'b0000);
        new_cmp_config = 1'b0;
        #1;
        check("cfg_resume_rd", word_rd_en, 1);
        check("cfg_app_off", config_applied, 0);
        cyc(4'b0000);
        check("cfg_resume_wr", core_wr_en, 4'b0010);
        check("cfg_resume_word", core_word, wv(12));

        push(13, 1'b1);
        #1;
        check("co_rd", word_rd_en, 1);
        cyc(4'b0000);
        new_cmp_config = 1'b1;
        push(14, 1'b0);
        #1;
        check("co_wr", core_wr_en, 4'b0100);
        check("co_rd_blk", word_rd_en, 0);
        cyc(4'b0110);
        check("co_rd_blk2", word_rd_en, 0);
        cyc(4'b0000);
        check("co_busy0", busy_mask, 0);
        check("co_gd_early", gen_done, 0);
        cyc(4'b0000);
        check("co_gen_done", gen_done, 1);
        check("co_num", num_processed, 4);
        check("co_app_not_yet", config_applied, 0);
        check("co_rd_rep", word_rd_en, 0);
        cyc(4'b0000);
        check("co_gd_off", gen_done, 0);
        check("co_rd_run", word_rd_en, 0);
        cyc(4'b0000);
        check("co_app_drain", config_applied, 0);
        cyc(4'b0000);
        check("co_applied", config_applied, 1);
        check("co_rd_apply", word_rd_en, 0);
        cyc(4'b0000);
        new_cmp_config = 1'b0;
        #1;
        check("co_resume_rd", word_rd_en, 1);
        cyc(4'b0000);
        check("co_resume_wr", core_wr_en, 4'b1000);
        check("co_resume_word", core_word, wv(14));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
